// File: rtl/fast_pkg.sv
// Shared definitions for the FAST ring fetch path: ring geometry, the offset
// LUT, the fetcher state encoding and the read-tag payload.
package fast_pkg;

  localparam int unsigned NUM_RING  = 16;
  localparam int unsigned RING_R    = 3;
  localparam int unsigned NUM_READS = NUM_RING + 1;
  localparam int unsigned TAG_IDX_W = 5;

  // Ring offsets, index 0..15, clockwise starting straight above the center.
  localparam int RING_DX [NUM_RING] = '{ 0,  1,  2,  3,  3,  3,  2,  1,
                                         0, -1, -2, -3, -3, -3, -2, -1};
  localparam int RING_DY [NUM_RING] = '{-3, -3, -2, -1,  0,  1,  2,  3,
                                         3,  3,  2,  1,  0, -1, -2, -3};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    REJECT,
    HOLD
  } state_t;

  // Tag travelling alongside each read: idx 0 is the center, 1..16 is ring[idx-1].
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/fast_addr_gen.sv
// Combinational read-address generator: center + ring offset for read index,
// optionally saturated to the image bounds.
// Ports:
//   center_x_i/center_y_i : center coordinate
//   idx_i                 : read index (0 = center, 1..16 = ring[idx-1])
//   x_addr_o/y_addr_o     : resulting read address
module fast_addr_gen
  import fast_pkg::*;
#(
  parameter int unsigned COORD_W     = 9,
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned BORDER_MODE = 0
) (
  input  logic [COORD_W-1:0]   center_x_i,
  input  logic [COORD_W-1:0]   center_y_i,
  input  logic [TAG_IDX_W-1:0] idx_i,
  output logic [COORD_W-1:0]   x_addr_o,
  output logic [COORD_W-1:0]   y_addr_o
);

  localparam int unsigned AW = COORD_W + 1;

  logic [3:0]          ring_i;
  logic signed [AW-1:0] dx;
  logic signed [AW-1:0] dy;
  logic signed [AW-1:0] sx;
  logic signed [AW-1:0] sy;

  // Clamp mode saturates to [0, lim-1]; reject mode only sees interior centers.
  function automatic logic [COORD_W-1:0] fit(input logic signed [AW-1:0] v,
                                             input int unsigned lim);
    logic [COORD_W-1:0] r;
    r = v[COORD_W-1:0];
    if (BORDER_MODE == 0) begin
      if (v[AW-1]) begin
        r = '0;
      end else if (v[COORD_W-1:0] > COORD_W'(lim - 1)) begin
        r = COORD_W'(lim - 1);
      end
    end
    return r;
  endfunction

  // Offset lookup and signed address arithmetic.
  always_comb begin
    ring_i = 4'(idx_i - TAG_IDX_W'(1));
    dx     = '0;
    dy     = '0;
    if (idx_i != '0) begin
      dx = AW'(RING_DX[ring_i]);
      dy = AW'(RING_DY[ring_i]);
    end
    sx       = $signed({1'b0, center_x_i}) + dx;
    sy       = $signed({1'b0, center_y_i}) + dy;
    x_addr_o = fit(sx, IMG_W);
    y_addr_o = fit(sy, IMG_H);
  end

endmodule

// File: rtl/fast_ring_fetcher.sv
// Fetches the center pixel and the 16-point radius-3 FAST ring around a
// coordinate, one frame-buffer read per cycle, and presents all 17 values
// in parallel behind a valid/ready handshake.
// Ports:
//   clk, n_rst            : clock, async active-low reset
//   start, curr_x, curr_y : fetch request (accepted only when idle)
//   rd_en, x_addr, y_addr : frame-buffer read port request
//   rd_data               : read data, RD_LAT cycles after the rd_en cycle
//   busy                  : not idle
//   ring_valid/ring_ready : result handshake
//   ring_pix, center_pix  : fetched pixels
//   border_flag           : center within 3 px of an image edge
module fast_ring_fetcher
  import fast_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned COORD_W     = 9,
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned BORDER_MODE = 0
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  input  logic [COORD_W-1:0]               curr_x,
  input  logic [COORD_W-1:0]               curr_y,
  output logic                             rd_en,
  output logic [COORD_W-1:0]               x_addr,
  output logic [COORD_W-1:0]               y_addr,
  input  logic [PIX_W-1:0]                 rd_data,
  output logic                             busy,
  output logic                             ring_valid,
  input  logic                             ring_ready,
  output logic [NUM_RING-1:0][PIX_W-1:0]   ring_pix,
  output logic [PIX_W-1:0]                 center_pix,
  output logic                             border_flag
);

  localparam logic [TAG_IDX_W-1:0] LAST_IDX = TAG_IDX_W'(NUM_READS - 1);

  state_t                          state_q, state_d;
  logic [COORD_W-1:0]              cx_q, cx_d;
  logic [COORD_W-1:0]              cy_q, cy_d;
  logic [TAG_IDX_W-1:0]            idx_q, idx_d;
  logic                            rd_en_q, rd_en_d;
  logic [COORD_W-1:0]              x_addr_q, x_addr_d;
  logic [COORD_W-1:0]              y_addr_q, y_addr_d;
  logic                            busy_q, busy_d;
  logic                            ring_valid_q, ring_valid_d;
  logic                            border_q, border_d;
  logic [PIX_W-1:0]                center_q, center_d;
  logic [NUM_RING-1:0][PIX_W-1:0]  ring_q, ring_d;

  tag_t                            pipe_q [RD_LAT];
  tag_t                            tag_in;
  tag_t                            tag_out;
  logic                            near_edge_c;
  logic [COORD_W-1:0]              ag_x, ag_y;

  function automatic logic near_edge(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (x < COORD_W'(RING_R)) || (x > COORD_W'(IMG_W - RING_R - 1)) ||
           (y < COORD_W'(RING_R)) || (y > COORD_W'(IMG_H - RING_R - 1));
  endfunction

  assign near_edge_c = near_edge(curr_x, curr_y);

  // The tag enters the pipe at the end of its rd_en cycle, so the pipe output
  // lines up with the cycle in which rd_data carries that read.
  assign tag_in.valid = rd_en_q;
  assign tag_in.idx   = idx_q;
  assign tag_out      = pipe_q[RD_LAT-1];

  // Next state, latched request and capture registers.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    border_d = border_q;
    center_d = center_q;
    ring_d   = ring_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cx_d     = curr_x;
          cy_d     = curr_y;
          border_d = near_edge_c;
          idx_d    = '0;
          state_d  = ((BORDER_MODE == 1) && near_edge_c) ? REJECT : ISSUE;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + TAG_IDX_W'(1);
        end
      end
      DRAIN: begin
        if (tag_out.valid && (tag_out.idx == LAST_IDX)) begin
          state_d = HOLD;
        end
      end
      REJECT: begin
        center_d = '0;
        ring_d   = '0;
        state_d  = HOLD;
      end
      HOLD: begin
        if (ring_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tag_out.valid) begin
      if (tag_out.idx == '0) begin
        center_d = rd_data;
      end else begin
        ring_d[4'(tag_out.idx - TAG_IDX_W'(1))] = rd_data;
      end
    end
  end

  fast_addr_gen #(
    .COORD_W    (COORD_W),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .BORDER_MODE(BORDER_MODE)
  ) u_addr_gen (
    .center_x_i(cx_d),
    .center_y_i(cy_d),
    .idx_i     (idx_d),
    .x_addr_o  (ag_x),
    .y_addr_o  (ag_y)
  );

  // Registered read port and status outputs, derived from the next state.
  always_comb begin
    rd_en_d      = (state_d == ISSUE);
    x_addr_d     = '0;
    y_addr_d     = '0;
    if (rd_en_d) begin
      x_addr_d = ag_x;
      y_addr_d = ag_y;
    end
    busy_d       = (state_d != IDLE);
    ring_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      idx_q        <= '0;
      rd_en_q      <= 1'b0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      busy_q       <= 1'b0;
      ring_valid_q <= 1'b0;
      border_q     <= 1'b0;
      center_q     <= '0;
      ring_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      x_addr_q     <= x_addr_d;
      y_addr_q     <= y_addr_d;
      busy_q       <= busy_d;
      ring_valid_q <= ring_valid_d;
      border_q     <= border_d;
      center_q     <= center_d;
      ring_q       <= ring_d;
      pipe_q[0]    <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign x_addr      = x_addr_q;
  assign y_addr      = y_addr_q;
  assign busy        = busy_q;
  assign ring_valid  = ring_valid_q;
  assign border_flag = border_q;
  assign center_pix  = center_q;
  assign ring_pix    = ring_q;

endmodule

// File: tb/tb_fast_ring_fetcher.sv
// Bench for fast_ring_fetcher: three instances (clamp/RD_LAT=1, reject/RD_LAT=1,
// clamp/RD_LAT=3) against a behavioural frame buffer and ring model.
module tb_fast_ring_fetcher;

  localparam int NI = 3;
  localparam int DLAT [NI] = '{1, 1, 3};
  localparam int DBM  [NI] = '{0, 1, 0};
  localparam int TDX  [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int TDY  [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic                 start_s [NI];
  logic [8:0]           cx_s    [NI];
  logic [8:0]           cy_s    [NI];
  logic                 rdy_s   [NI];
  logic                 rd_en_s [NI];
  logic [8:0]           xa_s    [NI];
  logic [8:0]           ya_s    [NI];
  logic [7:0]           rdd_s   [NI];
  logic                 busy_s  [NI];
  logic                 rv_s    [NI];
  logic                 bf_s    [NI];
  logic [15:0][7:0]     ring_s  [NI];
  logic [7:0]           cen_s   [NI];

  logic [7:0] mpipe [NI][4];
  bit         mem_mode;
  int         n_checks = 0;
  int         n_fail   = 0;

  fast_ring_fetcher #(.RD_LAT(1), .BORDER_MODE(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .start(start_s[0]), .curr_x(cx_s[0]), .curr_y(cy_s[0]),
    .rd_en(rd_en_s[0]), .x_addr(xa_s[0]), .y_addr(ya_s[0]), .rd_data(rdd_s[0]),
    .busy(busy_s[0]), .ring_valid(rv_s[0]), .ring_ready(rdy_s[0]),
    .ring_pix(ring_s[0]), .center_pix(cen_s[0]), .border_flag(bf_s[0]));

  fast_ring_fetcher #(.RD_LAT(1), .BORDER_MODE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .start(start_s[1]), .curr_x(cx_s[1]), .curr_y(cy_s[1]),
    .rd_en(rd_en_s[1]), .x_addr(xa_s[1]), .y_addr(ya_s[1]), .rd_data(rdd_s[1]),
    .busy(busy_s[1]), .ring_valid(rv_s[1]), .ring_ready(rdy_s[1]),
    .ring_pix(ring_s[1]), .center_pix(cen_s[1]), .border_flag(bf_s[1]));

  fast_ring_fetcher #(.RD_LAT(3), .BORDER_MODE(0)) dut2 (
    .clk(clk), .n_rst(n_rst), .start(start_s[2]), .curr_x(cx_s[2]), .curr_y(cy_s[2]),
    .rd_en(rd_en_s[2]), .x_addr(xa_s[2]), .y_addr(ya_s[2]), .rd_data(rdd_s[2]),
    .busy(busy_s[2]), .ring_valid(rv_s[2]), .ring_ready(rdy_s[2]),
    .ring_pix(ring_s[2]), .center_pix(cen_s[2]), .border_flag(bf_s[2]));

  function automatic logic [7:0] pix_fn(input int x, input int y, input bit mode);
    if (mode) return 8'(x * 37 + y * 101 + x * y);
    return 8'(x + 2 * y);
  endfunction

  // Frame buffer: a read issued in cycle c shows its data in cycle c+RD_LAT;
  // outside that slot the bus carries junk.
  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      for (int s = 3; s > 0; s--) mpipe[d][s] <= mpipe[d][s-1];
      mpipe[d][0] <= rd_en_s[d] ? pix_fn(int'(xa_s[d]), int'(ya_s[d]), mem_mode)
                                : 8'($urandom);
    end
  end
  assign rdd_s[0] = mpipe[0][0];
  assign rdd_s[1] = mpipe[1][0];
  assign rdd_s[2] = mpipe[2][2];

  // Expected pixel for read k (0 = center, 1..16 = ring[k-1]) with edge saturation.
  function automatic logic [7:0] model_pix(input int cx, input int cy, input int k,
                                           input bit mode);
    int px, py;
    px = cx + ((k == 0) ? 0 : TDX[k-1]);
    py = cy + ((k == 0) ? 0 : TDY[k-1]);
    if (px < 0) px = 0;
    if (px > 319) px = 319;
    if (py < 0) py = 0;
    if (py > 239) py = 239;
    return pix_fn(px, py, mode);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request on instance d starting at a negedge in IDLE; returns at
  // the negedge of the first IDLE cycle after the handshake.
  task automatic fetch(input int d, input int x, input int y, input int hold);
    int n, first_v, nrd, first_rd, last_rd, bad_addr, lat_exp;
    bit brd, rej;
    logic [7:0]       snap_c;
    logic [15:0][7:0] snap_r;
    logic             snap_b;
    brd     = (x < 3) || (x > 316) || (y < 3) || (y > 236);
    rej     = (DBM[d] == 1) && brd;
    lat_exp = rej ? 2 : 18 + DLAT[d];
    cx_s[d] = 9'(x);
    cy_s[d] = 9'(y);
    start_s[d] = 1'b1;
    rdy_s[d]   = (hold == 0);
    @(posedge clk);
    #1 start_s[d] = 1'b0;
    n = 0; first_v = 0; nrd = 0; first_rd = 0; last_rd = 0; bad_addr = 0;
    while (first_v == 0 && n < 60) begin
      n++;
      @(negedge clk);
      if (rd_en_s[d]) begin
        nrd++;
        if (first_rd == 0) first_rd = n;
        last_rd = n;
        if (xa_s[d] >= 9'd320 || ya_s[d] >= 9'd240) bad_addr++;
      end else if (xa_s[d] != 9'd0 || ya_s[d] != 9'd0) begin
        bad_addr++;
      end
      if (rv_s[d]) first_v = n;
    end
    if (first_v == 0) begin
      chk("ring_valid_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(first_v), 32'(lat_exp));
    chk("rd_en_count", 32'(nrd), rej ? 32'd0 : 32'd17);
    chk("rd_en_span", (nrd > 0) ? 32'(last_rd - first_rd + 1) : 32'd0,
        rej ? 32'd0 : 32'd17);
    chk("addr_range", 32'(bad_addr), 32'd0);
    chk("border_flag", 32'(bf_s[d]), 32'(brd));
    chk("busy_in_hold", 32'(busy_s[d]), 32'd1);
    chk("center", 32'(cen_s[d]), rej ? 32'd0 : 32'(model_pix(x, y, 0, mem_mode)));
    for (int k = 0; k < 16; k++)
      chk($sformatf("ring%0d", k), 32'(ring_s[d][k]),
          rej ? 32'd0 : 32'(model_pix(x, y, k + 1, mem_mode)));
    snap_c = cen_s[d];
    snap_r = ring_s[d];
    snap_b = bf_s[d];
    for (int h = 0; h < hold; h++) begin
      cx_s[d]    = 9'($urandom_range(0, 319));
      cy_s[d]    = 9'($urandom_range(0, 239));
      start_s[d] = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(rv_s[d]), 32'd1);
      chk("bp_busy", 32'(busy_s[d]), 32'd1);
      chk("bp_center_stable", 32'(cen_s[d]), 32'(snap_c));
      chk("bp_ring_stable", 32'(ring_s[d] == snap_r), 32'd1);
      chk("bp_border_stable", 32'(bf_s[d]), 32'(snap_b));
    end
    start_s[d] = 1'b0;
    rdy_s[d]   = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy_s[d]), 32'd0);
    chk("idle_valid", 32'(rv_s[d]), 32'd0);
    chk("idle_center_held", 32'(cen_s[d]), 32'(snap_c));
  endtask

  initial begin
    n_rst    = 1'b0;
    mem_mode = 1'b0;
    for (int d = 0; d < NI; d++) begin
      start_s[d] = 1'b0;
      cx_s[d]    = '0;
      cy_s[d]    = '0;
      rdy_s[d]   = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en_s[0]), 32'd0);
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_valid", 32'(rv_s[2]), 32'd0);
    chk("rst_center", 32'(cen_s[1]), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Default configuration, interior center.
    fetch(0, 10, 10, 0);
    chk("t1_center", 32'(cen_s[0]), 32'd30);
    chk("t1_ring0", 32'(ring_s[0][0]), 32'd24);
    chk("t1_ring4", 32'(ring_s[0][4]), 32'd33);
    chk("t1_ring12", 32'(ring_s[0][12]), 32'd27);
    chk("t1_border", 32'(bf_s[0]), 32'd0);

    // Clamp at the corner.
    fetch(0, 1, 1, 0);
    chk("clamp_ring12", 32'(ring_s[0][12]), 32'd2);
    chk("clamp_ring0", 32'(ring_s[0][0]), 32'd1);
    chk("clamp_border", 32'(bf_s[0]), 32'd1);

    // Reject at the corner, then an interior fetch on the same instance.
    fetch(1, 1, 1, 0);
    chk("rej_border", 32'(bf_s[1]), 32'd1);
    chk("rej_ring5", 32'(ring_s[1][5]), 32'd0);
    fetch(1, 40, 30, 0);

    // Backpressure, then immediate new request.
    fetch(0, 50, 60, 5);
    fetch(0, 200, 100, 0);

    // Longer read latency.
    fetch(2, 100, 50, 0);
    chk("lat3_center", 32'(cen_s[2]), 32'd200);

    // Randomized requests with a less regular frame buffer.
    mem_mode = 1'b1;
    for (int i = 0; i < 6; i++)
      fetch(0, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), 0);
    for (int i = 0; i < 4; i++)
      fetch(2, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)),
            int'($urandom_range(0, 2)));
    for (int i = 0; i < 6; i++)
      fetch(1, (i % 2 == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 316)),
            int'($urandom_range(3, 236)), 0);

    // Reset in the middle of the read burst.
    mem_mode = 1'b0;
    cx_s[0] = 9'd150;
    cy_s[0] = 9'd120;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_rd_en", 32'(rd_en_s[0]), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en_s[0]), 32'd0);
    chk("mid_rst_xaddr", 32'(xa_s[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_s[0]), 32'd0);
    chk("mid_rst_valid", 32'(rv_s[0]), 32'd0);
    chk("mid_rst_center", 32'(cen_s[0]), 32'd0);
    chk("mid_rst_ring_zero", 32'(ring_s[0] == '0), 32'd1);
    chk("mid_rst_border", 32'(bf_s[0]), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_no_capture_c", 32'(cen_s[0]), 32'd0);
    chk("post_rst_no_capture_r", 32'(ring_s[0] == '0), 32'd1);
    chk("post_rst_idle", 32'(busy_s[0]), 32'd0);
    fetch(0, 150, 120, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
